// File: rtl/gate_vector_monitor_if.sv
// gate_vector_monitor_if: gate command inputs and decoded/measured outputs of the gate vector monitor
interface gate_vector_monitor_if #(parameter int CNT_W = 14);
  logic K1_A_H, K2_A_L, K3_B_H, K4_B_L, K5_C_H, K6_C_L;
  logic period_tick, clear_fault;
  logic [2:0] vector;
  logic vector_ok, blocked, phase_a_off;
  logic [CNT_W-1:0] t_v1, t_v2, t_v0;
  logic [2:0] v1_seen, v2_seen;
  logic [3:0] sector_est;
  logic meas_valid, shoot_fault, seq_fault;
  modport master(
    output K1_A_H, K2_A_L, K3_B_H, K4_B_L, K5_C_H, K6_C_L, period_tick, clear_fault,
    input vector, vector_ok, blocked, phase_a_off, t_v1, t_v2, t_v0, v1_seen, v2_seen,
    input sector_est, meas_valid, shoot_fault, seq_fault
  );
  modport slave(
    input K1_A_H, K2_A_L, K3_B_H, K4_B_L, K5_C_H, K6_C_L, period_tick, clear_fault,
    output vector, vector_ok, blocked, phase_a_off, t_v1, t_v2, t_v0, v1_seen, v2_seen,
    output sector_est, meas_valid, shoot_fault, seq_fault
  );
endinterface

// File: rtl/gate_vector_monitor.sv
// gate_vector_monitor: decodes K1..K6 into the applied vector, measures per-period dwell times and flags faults
module gate_vector_monitor #(parameter int CNT_W = 14) (
  input logic clk,
  input logic rst,
  gate_vector_monitor_if.slave bus
);
  typedef enum logic {SYNC, RUN} state_e;
  state_e state_q, state_d;
  logic [5:0] k_q;
  logic tick_q, clr_q, vld_q;
  logic [2:0] bit_v, blk, sht;
  logic ok, all_blk, a_off, cnt_en, zero, latch, seq_set;
  logic [2:0] vec_q, sl1_q, sl1_d, sl1_b, sl2_q, sl2_d, sl2_b, v1_q, v2_q;
  logic ok_q, blk_q, aoff_q, shoot_q, seq_q, mv_q;
  logic [CNT_W-1:0] t1_q, t1_d, t1_b, t2_q, t2_d, t2_b, t0_q, t0_d, t0_b, tv1_q, tv2_q, tv0_q;
  logic [3:0] sec_d, sec_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '1;
      tick_q <= 1'b0;
      clr_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      k_q <= {bus.K1_A_H, bus.K2_A_L, bus.K3_B_H, bus.K4_B_L, bus.K5_C_H, bus.K6_C_L};
      tick_q <= bus.period_tick;
      clr_q <= bus.clear_fault;
      vld_q <= 1'b1;
    end
  end
  for (genvar i = 0; i < 3; i++) begin : g_dec
    assign bit_v[i] = ~k_q[2*i+1] & k_q[2*i];
    assign blk[i] = k_q[2*i+1] & k_q[2*i];
    assign sht[i] = ~k_q[2*i+1] & ~k_q[2*i];
  end
  assign ok = ~|blk & ~|sht;
  assign all_blk = vld_q & &blk;
  assign a_off = blk[2] & ~|blk[1:0] & ~|sht[1:0];
  assign cnt_en = ok | a_off;
  assign zero = bit_v == 3'b000 || bit_v == 3'b111;
  assign latch = tick_q && state_q == RUN;
  // a tick restarts the window, so this cycle's sample lands in the new one
  always_comb begin
    t1_b = tick_q ? '0 : t1_q;
    t2_b = tick_q ? '0 : t2_q;
    t0_b = tick_q ? '0 : t0_q;
    sl1_b = tick_q ? 3'b000 : sl1_q;
    sl2_b = tick_q ? 3'b000 : sl2_q;
    t1_d = t1_b;
    t2_d = t2_b;
    t0_d = t0_b;
    sl1_d = sl1_b;
    sl2_d = sl2_b;
    seq_set = 1'b0;
    if (cnt_en) begin
      if (zero) t0_d = t0_b + CNT_W'(t0_b != '1);
      else if (sl1_b == 3'b000 || sl1_b == bit_v) begin
        sl1_d = bit_v;
        t1_d = t1_b + CNT_W'(t1_b != '1);
      end else if (sl2_b == 3'b000 || sl2_b == bit_v) begin
        sl2_d = bit_v;
        t2_d = t2_b + CNT_W'(t2_b != '1);
      end else seq_set = 1'b1;
    end
  end
  always_comb begin
    state_d = tick_q ? RUN : state_q;
    case ({sl1_q, sl2_q})
      6'b100_110: sec_d = 4'd1;
      6'b110_100: sec_d = 4'd2;
      6'b110_010: sec_d = 4'd3;
      6'b010_110: sec_d = 4'd4;
      6'b010_011: sec_d = 4'd5;
      6'b011_010: sec_d = 4'd6;
      6'b011_001: sec_d = 4'd7;
      6'b001_011: sec_d = 4'd8;
      6'b001_101: sec_d = 4'd9;
      6'b101_001: sec_d = 4'd10;
      6'b101_100: sec_d = 4'd11;
      6'b100_101: sec_d = 4'd12;
      default:    sec_d = 4'd0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      vec_q <= 3'b000;
      ok_q <= 1'b0;
      blk_q <= 1'b0;
      aoff_q <= 1'b0;
      shoot_q <= 1'b0;
      seq_q <= 1'b0;
      t1_q <= '0;
      t2_q <= '0;
      t0_q <= '0;
      sl1_q <= 3'b000;
      sl2_q <= 3'b000;
      tv1_q <= '0;
      tv2_q <= '0;
      tv0_q <= '0;
      v1_q <= 3'b000;
      v2_q <= 3'b000;
      sec_q <= 4'd0;
      mv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= bit_v;
      ok_q <= ok;
      blk_q <= all_blk;
      aoff_q <= a_off;
      shoot_q <= |sht | (shoot_q & ~clr_q);
      seq_q <= seq_set | (seq_q & ~clr_q);
      t1_q <= t1_d;
      t2_q <= t2_d;
      t0_q <= t0_d;
      sl1_q <= sl1_d;
      sl2_q <= sl2_d;
      mv_q <= latch;
      if (latch) begin
        tv1_q <= t1_q;
        tv2_q <= t2_q;
        tv0_q <= t0_q;
        v1_q <= sl1_q;
        v2_q <= sl2_q;
        sec_q <= sec_d;
      end
    end
  end
  assign bus.vector = vec_q;
  assign bus.vector_ok = ok_q;
  assign bus.blocked = blk_q;
  assign bus.phase_a_off = aoff_q;
  assign bus.t_v1 = tv1_q;
  assign bus.t_v2 = tv2_q;
  assign bus.t_v0 = tv0_q;
  assign bus.v1_seen = v1_q;
  assign bus.v2_seen = v2_q;
  assign bus.sector_est = sec_q;
  assign bus.meas_valid = mv_q;
  assign bus.shoot_fault = shoot_q;
  assign bus.seq_fault = seq_q;
endmodule

// File: tb/tb_gate_vector_monitor.sv
// tb_gate_vector_monitor: decode vector table, scoreboarded period measurements and fault/reset sequences
module tb_gate_vector_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gate_vector_monitor_if #(.CNT_W(14)) bus();
  gate_vector_monitor #(.CNT_W(14)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct { logic [13:0] t1, t2, t0; logic [2:0] v1, v2; logic [3:0] sec; } meas_t;
  typedef struct { logic [5:0] k; logic [2:0] vec; logic ok, blk, aoff; } vec_t;
  meas_t exp_q[$];
  meas_t pend;
  bit armed = 0;
  int checks = 0, errors = 0;
  vec_t tbl[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic meas_t mk(input int t1, t2, t0, input logic [2:0] v1, v2, input logic [3:0] sec);
    mk.t1 = 14'(t1);
    mk.t2 = 14'(t2);
    mk.t0 = 14'(t0);
    mk.v1 = v1;
    mk.v2 = v2;
    mk.sec = sec;
  endfunction
  function automatic logic [5:0] enc(input logic [2:0] v);
    enc = {v[2] ? 2'b01 : 2'b10, v[1] ? 2'b01 : 2'b10, v[0] ? 2'b01 : 2'b10};
  endfunction
  task automatic drive_raw(input logic [5:0] k, input logic tick, input logic clr);
    {bus.K1_A_H, bus.K2_A_L, bus.K3_B_H, bus.K4_B_L, bus.K5_C_H, bus.K6_C_L} = k;
    bus.period_tick = tick;
    bus.clear_fault = clr;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [2:0] v, input logic tick);
    drive_raw(enc(v), tick, 1'b0);
  endtask
  task automatic start(input meas_t e);
    if (armed) exp_q.push_back(pend);
    armed = 1;
    pend = e;
  endtask
  task automatic period(input logic [2:0] va, input int na, input logic [2:0] vb, input int nb,
                        input logic [2:0] vz, input int nz, input meas_t e);
    start(e);
    for (int i = 0; i < na + nb + nz; i++) drive(i < na ? va : (i < na + nb ? vb : vz), i == 0);
  endtask
  task automatic close();
    period(3'b000, 0, 3'b000, 0, 3'b000, 6, mk(0, 0, 6, 3'b000, 3'b000, 0));
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_vector"}, bus.vector, 0);
    chk({tag, "_vector_ok"}, bus.vector_ok, 0);
    chk({tag, "_blocked"}, bus.blocked, 0);
    chk({tag, "_phase_a_off"}, bus.phase_a_off, 0);
    chk({tag, "_t_v1"}, bus.t_v1, 0);
    chk({tag, "_t_v2"}, bus.t_v2, 0);
    chk({tag, "_t_v0"}, bus.t_v0, 0);
    chk({tag, "_v1_seen"}, bus.v1_seen, 0);
    chk({tag, "_v2_seen"}, bus.v2_seen, 0);
    chk({tag, "_sector_est"}, bus.sector_est, 0);
    chk({tag, "_meas_valid"}, bus.meas_valid, 0);
    chk({tag, "_shoot_fault"}, bus.shoot_fault, 0);
    chk({tag, "_seq_fault"}, bus.seq_fault, 0);
  endtask
  always @(negedge clk) begin
    meas_t e;
    if (!rst && bus.meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL meas_unexpected: got meas_valid=1 expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("meas_t_v1", bus.t_v1, e.t1);
        chk("meas_t_v2", bus.t_v2, e.t2);
        chk("meas_t_v0", bus.t_v0, e.t0);
        chk("meas_v1_seen", bus.v1_seen, e.v1);
        chk("meas_v2_seen", bus.v2_seen, e.v2);
        chk("meas_sector_est", bus.sector_est, e.sec);
      end
    end
  end
  initial begin
    tbl[0] = '{6'b011010, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{6'b100101, 3'b011, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{6'b010101, 3'b111, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{6'b101010, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{6'b111111, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{6'b110110, 3'b010, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{6'b011110, 3'b100, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{6'b111101, 3'b001, 1'b0, 1'b0, 1'b0};
    rst = 1'b1;
    repeat (3) drive(3'b000, 1'b0);
    check_reset("rst");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_raw(tbl[i].k, 1'b0, 1'b0);
      drive_raw(tbl[i].k, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_vector", i), bus.vector, tbl[i].vec);
      chk($sformatf("tbl%0d_vector_ok", i), bus.vector_ok, tbl[i].ok);
      chk($sformatf("tbl%0d_blocked", i), bus.blocked, tbl[i].blk);
      chk($sformatf("tbl%0d_phase_a_off", i), bus.phase_a_off, tbl[i].aoff);
    end
    rst = 1'b1;
    repeat (2) drive(3'b000, 1'b0);
    rst = 1'b0;
    armed = 0;
    repeat (2) drive(3'b000, 1'b0);
    chk("shoot_idle", bus.shoot_fault, 0);
    drive_raw(6'b010010, 1'b0, 1'b0);
    drive(3'b000, 1'b0);
    chk("shoot_set", bus.shoot_fault, 1);
    repeat (3) drive(3'b000, 1'b0);
    chk("shoot_hold", bus.shoot_fault, 1);
    drive_raw(enc(3'b000), 1'b0, 1'b1);
    drive(3'b000, 1'b0);
    chk("shoot_clear", bus.shoot_fault, 0);
    drive_raw(6'b010010, 1'b0, 1'b1);
    drive(3'b000, 1'b0);
    chk("shoot_set_with_clear", bus.shoot_fault, 1);
    drive_raw(enc(3'b000), 1'b0, 1'b1);
    drive(3'b000, 1'b0);
    chk("shoot_clear2", bus.shoot_fault, 0);
    repeat (3) period(3'b100, 300, 3'b110, 200, 3'b111, 500, mk(300, 200, 500, 3'b100, 3'b110, 1));
    repeat (2) period(3'b101, 250, 3'b001, 350, 3'b000, 400, mk(250, 350, 400, 3'b101, 3'b001, 10));
    period(3'b000, 0, 3'b000, 0, 3'b000, 1000, mk(0, 0, 1000, 3'b000, 3'b000, 0));
    start(mk(300, 200, 450, 3'b100, 3'b110, 1));
    for (int i = 0; i < 950; i++) drive(i < 300 ? 3'b100 : (i < 500 ? 3'b110 : 3'b111), i == 0);
    for (int i = 0; i < 50; i++) begin
      drive_raw(6'b111111, 1'b0, 1'b0);
      if (i == 1) begin
        chk("blocked_flag", bus.blocked, 1);
        chk("blocked_vector", bus.vector, 0);
      end
    end
    start(mk(300, 200, 500, 3'b100, 3'b110, 1));
    for (int i = 0; i < 900; i++) drive(i < 300 ? 3'b100 : (i < 500 ? 3'b110 : 3'b111), i == 0);
    for (int i = 0; i < 100; i++) begin
      drive_raw(6'b111010, 1'b0, 1'b0);
      if (i == 1) begin
        chk("aoff_flag", bus.phase_a_off, 1);
        chk("aoff_vector_ok", bus.vector_ok, 0);
      end
    end
    period(3'b100, 20000, 3'b000, 0, 3'b000, 0, mk(16383, 0, 0, 3'b100, 3'b000, 0));
    chk("seq_idle", bus.seq_fault, 0);
    period(3'b100, 10, 3'b110, 10, 3'b010, 10, mk(10, 10, 0, 3'b100, 3'b110, 1));
    chk("seq_set", bus.seq_fault, 1);
    period(3'b100, 1, 3'b000, 0, 3'b000, 0, mk(1, 0, 0, 3'b100, 3'b000, 0));
    period(3'b110, 1, 3'b000, 0, 3'b000, 0, mk(1, 0, 0, 3'b110, 3'b000, 0));
    close();
    chk("seq_hold", bus.seq_fault, 1);
    drive_raw(enc(3'b000), 1'b0, 1'b1);
    drive(3'b000, 1'b0);
    chk("seq_clear", bus.seq_fault, 0);
    chk("queue_drained", exp_q.size(), 0);
    repeat (300) drive(3'b100, 1'b0);
    rst = 1'b1;
    repeat (2) drive(3'b100, 1'b0);
    check_reset("midrst");
    rst = 1'b0;
    armed = 0;
    repeat (2) period(3'b100, 300, 3'b110, 200, 3'b111, 500, mk(300, 200, 500, 3'b100, 3'b110, 1));
    close();
    chk("queue_final", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_vector_monitor.md
# gate_vector_monitor

Receive-side counterpart of the SVPWM vector/gate generator: samples the six switch commands K1..K6 driven to the inverter, decodes them back into the applied voltage vector, and measures per-PWM-period dwell times of the first active, second active and zero vectors. From the order of the two active vectors it reconstructs the 12-sector number. It also flags shoot-through and illegal sequences. It sits beside the gate outputs and feeds the supervisory/diagnostic logic and the loopback checks of the T1/T2/T0 calculation.

## Interface
- CNT_W, 14, width of dwell counters (matches T1/T2/T0 width)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- K1_A_H, K2_A_L, K3_B_H, K4_B_L, K5_C_H, K6_C_L  in  1 each  gate commands (active-low switch drive)
- period_tick  in  1  one-clk pulse marking the start of a PWM period (clk domain)
- clear_fault  in  1  clears sticky fault flags
- vector  out  3  decoded vector {A,B,C}, registered
- vector_ok  out  1  all three phases in a legal driven state this cycle
- blocked  out  1  all six commands high (bridge disabled)
- phase_a_off  out  1  phase A blocked, B and C driven (broken-phase mode)
- t_v1, t_v2, t_v0  out  CNT_W each  dwell counts of last complete period
- v1_seen, v2_seen  out  3 each  first and second active vector of last period
- sector_est  out  4  reconstructed sector 1..12, 0 = undetermined
- meas_valid  out  1  one-clk pulse when measurement outputs update
- shoot_fault  out  1  sticky: some phase had H=0 and L=0
- seq_fault  out  1  sticky: third distinct active vector within one period

## Operation
- Stage 1: register all six inputs and period_tick.
- Stage 2, per-phase decode of (H,L): (0,1) -> bit 1; (1,0) -> bit 0; (1,1) -> blocked, bit reads 0; (0,0) -> shoot-through, bit reads 0, sets shoot_fault.
- vector_ok = no phase blocked and no shoot-through. blocked = all three phases blocked. phase_a_off = A blocked, B and C legal.
- Window counting, once per clk after decode, when vector_ok or phase_a_off:
  - decoded 000 or 111 -> t0 counter +1.
  - active vector, slot1 empty or equal -> slot1 := vector, t1 +1.
  - else slot2 empty or equal -> slot2 := vector, t2 +1.
  - else seq_fault := 1, no count.
  - Cycles not meeting the condition (blocked, shoot-through) count nothing.
- Counters saturate at 2^CNT_W-1, never wrap.
- Registered period_tick closes the window: latch t1/t2/t0/slots into t_v1/t_v2/t_v0/v1_seen/v2_seen, compute sector_est, pulse meas_valid, clear counters and slots. The tick cycle's own sample counts into the new window.
- sector_est from ordered (v1,v2): (100,110)=1, (110,100)=2, (110,010)=3, (010,110)=4, (010,011)=5, (011,010)=6, (011,001)=7, (001,011)=8, (001,101)=9, (101,001)=10, (101,100)=11, (100,101)=12. Any other pair, including an empty slot, gives 0.
- FSM, states SYNC and RUN:
  - rst -> SYNC.
  - SYNC: counts but suppresses the latch and meas_valid on the first tick, then moves to RUN. The partial first window is discarded.
  - RUN: latches on every tick.
- Sticky faults: set by the condition, cleared only by clear_fault or rst. A same-cycle set and clear leaves the flag set.

## Timing
- Reset values: vector=000, vector_ok=0, blocked=0, phase_a_off=0, all t_*=0, v1_seen=v2_seen=000, sector_est=0, meas_valid=0, shoot_fault=0, seq_fault=0, FSM=SYNC.
- Latency from input pin to vector, vector_ok, blocked, phase_a_off and fault flags: 2 clk.
- Latency from period_tick to meas_valid: 2 clk. Measurement outputs change only on the meas_valid cycle and hold otherwise.
- Back-to-back ticks (1 clk apart) are legal: the window yields the counts of the single sample.
- rst mid-period drops all partial counts. The next tick is treated as the first tick in SYNC.

## Test plan
- Drive sector-1 pattern per period: vector 100 for 300 clk, 110 for 200, 111 for 500, tick every 1000. From the second tick onward, require t_v1=300, t_v2=200, t_v0=500, sector_est=1, meas_valid each period. The first tick gives no meas_valid.
- Sector-10 pattern 101/001/000. Require v1_seen=101, v2_seen=001, sector_est=10. Also a period containing only 000 gives sector_est=0, t_v0=1000.
- Drive phase B H=0, L=0 for 1 clk. Require shoot_fault=1 two clk later, held through clear_fault=0. clear_fault pulse clears it. A fault coincident with clear_fault stays set.
- Drive all six inputs high for 50 clk within a period. Require blocked=1, vector=000, and those 50 clk absent from t_v1+t_v2+t_v0. Drive A=(1,1) with B,C legal: require phase_a_off=1 and counting continues.
- Hold vector 100 for 20000 clk between ticks. Require t_v1=16383 (saturated). Three distinct active vectors in one period give seq_fault=1.
- Assert rst mid-period. Require all outputs at their reset values, and no meas_valid on the next tick.
